vga_timing_gen: RTL

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_pkg.sv | 29 ++
 rtl/vga_sync_counter.sv | 69 ++++++
 rtl/vga_timing_gen.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared FSM state type, counter widths, sync polarity and the
// bundle of programmable timing fields used by the VGA timing generator.
package vga_pkg;

  localparam int H_CNT_W = 11;
  localparam int V_CNT_W = 9;

  // Both sync outputs are driven to this level inside their pulse window.
  localparam logic SYNC_ACTIVE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } vga_state_e;

  // One frame's worth of timing, held in shadow registers while scanning.
  typedef struct packed {
    logic [10:0] hsync_end;
    logic [7:0]  hpulse_end;
    logic [7:0]  hdata_begin;
    logic [9:0]  hdata_end;
    logic [8:0]  vsync_end;
    logic [2:0]  vpulse_end;
    logic [4:0]  vdata_begin;
    logic [8:0]  vdata_end;
  } vga_timing_t;

endpackage

// File: rtl/vga_sync_counter.sv
// vga_sync_counter: horizontal (clock) and vertical (line) raster counters.
// The horizontal counter wraps after h_end_i clocks and the vertical counter
// advances on every horizontal wrap, wrapping after v_end_i lines.
module vga_sync_counter
  import vga_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clear_i,
  input  logic               count_en_i,
  input  logic [H_CNT_W-1:0] h_end_i,
  input  logic [V_CNT_W-1:0] v_end_i,
  output logic [H_CNT_W-1:0] h_o,
  output logic [V_CNT_W-1:0] v_o,
  output logic               frame_wrap_o
);

  localparam logic [H_CNT_W:0] H_ONE = {{H_CNT_W{1'b0}}, 1'b1};
  localparam logic [V_CNT_W:0] V_ONE = {{V_CNT_W{1'b0}}, 1'b1};

  logic [H_CNT_W-1:0] h_q, h_d;
  logic [V_CNT_W-1:0] v_q, v_d;
  logic [H_CNT_W:0]   h_end_eff, h_next;
  logic [V_CNT_W:0]   v_end_eff, v_next;
  logic               h_wrap, v_wrap;

  // Wrap detection on one-bit-wider sums; a programmed length of 0 acts as 1.
  always_comb begin
    h_end_eff = (h_end_i == '0) ? H_ONE : {1'b0, h_end_i};
    v_end_eff = (v_end_i == '0) ? V_ONE : {1'b0, v_end_i};
    h_next    = {1'b0, h_q} + H_ONE;
    v_next    = {1'b0, v_q} + V_ONE;
    h_wrap    = (h_next >= h_end_eff);
    v_wrap    = (v_next >= v_end_eff);
  end

  // Next counter values: hold when idle-cleared or not counting.
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (clear_i) begin
      h_d = '0;
      v_d = '0;
    end else if (count_en_i) begin
      if (h_wrap) begin
        h_d = '0;
        v_d = v_wrap ? '0 : v_next[V_CNT_W-1:0];
      end else begin
        h_d = h_next[H_CNT_W-1:0];
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h_o          = h_q;
  assign v_o          = v_q;
  assign frame_wrap_o = h_wrap && v_wrap;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: programmable VGA sync/blanking generator that pulls pixels
// from an upstream buffer. Timing inputs are shadowed once per frame.
// Define VGA_TIMING_TESTPAT_EN to build in the colour-bar self-test pattern.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int COLOR_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable_i,
  input  logic [10:0]              hsync_end_i,
  input  logic [7:0]               hpulse_end_i,
  input  logic [7:0]               hdata_begin_i,
  input  logic [9:0]               hdata_end_i,
  input  logic [8:0]               vsync_end_i,
  input  logic [2:0]               vpulse_end_i,
  input  logic [4:0]               vdata_begin_i,
  input  logic [8:0]               vdata_end_i,
  input  logic                     self_test_i,
  input  logic [3*COLOR_WIDTH-1:0] pixel_data_i,
  input  logic                     pixel_valid_i,
  output logic                     pixel_ready_o,
  output logic                     hsync_o,
  output logic                     vsync_o,
  output logic [COLOR_WIDTH-1:0]   red_o,
  output logic [COLOR_WIDTH-1:0]   green_o,
  output logic [COLOR_WIDTH-1:0]   blue_o,
  output logic                     de_o,
  output logic                     frame_start_o,
  output logic                     underflow_o,
  output logic [H_CNT_W-1:0]       hcount_o,
  output logic [V_CNT_W-1:0]       vcount_o
);

  localparam int RGB_W = 3 * COLOR_WIDTH;

  vga_state_e         state_q, state_d;
  vga_timing_t        timing_q, timing_d, timing_in;
  logic [H_CNT_W-1:0] h_cnt;
  logic [V_CNT_W-1:0] v_cnt;
  logic               frame_wrap;
  logic               running, active, hsync_act, vsync_act;
  logic               pattern_sel;
  logic [RGB_W-1:0]   pattern_rgb;

  logic               hsync_q, hsync_d, vsync_q, vsync_d;
  logic               de_q, de_d, frame_start_q, frame_start_d;
  logic               underflow_q, underflow_d;
  logic [RGB_W-1:0]   rgb_q, rgb_d;
  logic [H_CNT_W-1:0] hcount_q, hcount_d;
  logic [V_CNT_W-1:0] vcount_q, vcount_d;

  vga_sync_counter u_counter (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (!running),
    .count_en_i   (running),
    .h_end_i      (timing_q.hsync_end),
    .v_end_i      (timing_q.vsync_end),
    .h_o          (h_cnt),
    .v_o          (v_cnt),
    .frame_wrap_o (frame_wrap)
  );

  // Scan control: STOP lets the current frame finish unless re-enabled.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (enable_i) state_d = ST_RUN;
      ST_RUN:  if (!enable_i) state_d = ST_STOP;
      ST_STOP: begin
        if (enable_i)        state_d = ST_RUN;
        else if (frame_wrap) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Shadow the timing inputs only at scan start and at each frame wrap.
  always_comb begin
    timing_in.hsync_end   = hsync_end_i;
    timing_in.hpulse_end  = hpulse_end_i;
    timing_in.hdata_begin = hdata_begin_i;
    timing_in.hdata_end   = hdata_end_i;
    timing_in.vsync_end   = vsync_end_i;
    timing_in.vpulse_end  = vpulse_end_i;
    timing_in.vdata_begin = vdata_begin_i;
    timing_in.vdata_end   = vdata_end_i;
    timing_d = timing_q;
    if (((state_q == ST_IDLE) && enable_i) || ((state_q != ST_IDLE) && frame_wrap)) begin
      timing_d = timing_in;
    end
  end

  // Region decode from the live counters against the shadowed timing.
  always_comb begin
    running   = (state_q != ST_IDLE);
    hsync_act = running && (h_cnt < H_CNT_W'(timing_q.hpulse_end));
    vsync_act = running && (v_cnt < V_CNT_W'(timing_q.vpulse_end));
    active    = running
                && (h_cnt >= H_CNT_W'(timing_q.hdata_begin))
                && (h_cnt <  H_CNT_W'(timing_q.hdata_end))
                && (v_cnt >= V_CNT_W'(timing_q.vdata_begin))
                && (v_cnt <  timing_q.vdata_end);
  end

`ifdef VGA_TIMING_TESTPAT_EN
  logic [H_CNT_W-1:0] bar_offset;
  logic [2:0]         bar_idx;

  // Eight 64-pixel colour bars counted from the start of the active line.
  always_comb begin
    pattern_sel = self_test_i;
    bar_offset  = h_cnt - H_CNT_W'(timing_q.hdata_begin);
    bar_idx     = 3'(bar_offset >> 6);
    pattern_rgb = {{COLOR_WIDTH{bar_idx[2]}}, {COLOR_WIDTH{bar_idx[1]}},
                   {COLOR_WIDTH{bar_idx[0]}}};
  end
`else
  logic unused_self_test;

  // Without the pattern option the self-test input has no function.
  always_comb begin
    pattern_sel      = 1'b0;
    pattern_rgb      = '0;
    unused_self_test = self_test_i;
  end
`endif

  // The buffer is popped in the same cycle the counters sit in the active area.
  assign pixel_ready_o = active && !pattern_sel;

  // Output stage inputs; a missing pixel blanks RGB but keeps de asserted.
  always_comb begin
    hsync_d       = hsync_act ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vsync_d       = vsync_act ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    de_d          = active;
    rgb_d         = '0;
    underflow_d   = 1'b0;
    if (active) begin
      if (pattern_sel)        rgb_d = pattern_rgb;
      else if (pixel_valid_i) rgb_d = pixel_data_i;
      else                    underflow_d = 1'b1;
    end
    frame_start_d = (state_q == ST_RUN) && (h_cnt == '0) && (v_cnt == '0);
    hcount_d      = h_cnt;
    vcount_d      = v_cnt;
  end

  // State, shadow and registered video outputs; reset forces idle levels.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      timing_q      <= '0;
      hsync_q       <= ~SYNC_ACTIVE;
      vsync_q       <= ~SYNC_ACTIVE;
      de_q          <= 1'b0;
      rgb_q         <= '0;
      frame_start_q <= 1'b0;
      underflow_q   <= 1'b0;
      hcount_q      <= '0;
      vcount_q      <= '0;
    end else begin
      state_q       <= state_d;
      timing_q      <= timing_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      rgb_q         <= rgb_d;
      frame_start_q <= frame_start_d;
      underflow_q   <= underflow_d;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
    end
  end

  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign de_o          = de_q;
  assign red_o         = rgb_q[RGB_W-1 -: COLOR_WIDTH];
  assign green_o       = rgb_q[2*COLOR_WIDTH-1 -: COLOR_WIDTH];
  assign blue_o        = rgb_q[COLOR_WIDTH-1:0];
  assign frame_start_o = frame_start_q;
  assign underflow_o   = underflow_q;
  assign hcount_o      = hcount_q;
  assign vcount_o      = vcount_q;

endmodule
